// File: rtl/raw_hazard_scoreboard_if.sv
// ID/WB request and hazard-status signals of the decode-stage RAW hazard scoreboard.
// The master side is the pipeline, the slave side is the scoreboard itself.
interface raw_hazard_scoreboard_if #(
    parameter int unsigned ADDR_WIDTH = 5
);
    localparam int unsigned NREG = 2 ** ADDR_WIDTH;

    logic                  id_valid_i;
    logic [ADDR_WIDTH-1:0] id_rs1_addr_i;
    logic                  id_rs1_used_i;
    logic [ADDR_WIDTH-1:0] id_rs2_addr_i;
    logic                  id_rs2_used_i;
    logic [ADDR_WIDTH-1:0] id_rd_addr_i;
    logic                  id_rd_wren_i;
    logic                  id_flush_i;
    logic                  wb_valid_i;
    logic [ADDR_WIDTH-1:0] wb_rd_addr_i;
    logic                  wb_rd_wren_i;
    logic                  stall_o;
    logic                  issue_o;
    logic [NREG-1:0]       pending_o;
    logic                  err_o;

    modport master (
        output id_valid_i, id_rs1_addr_i, id_rs1_used_i, id_rs2_addr_i, id_rs2_used_i,
               id_rd_addr_i, id_rd_wren_i, id_flush_i, wb_valid_i, wb_rd_addr_i, wb_rd_wren_i,
        input  stall_o, issue_o, pending_o, err_o
    );

    modport slave (
        input  id_valid_i, id_rs1_addr_i, id_rs1_used_i, id_rs2_addr_i, id_rs2_used_i,
               id_rd_addr_i, id_rd_wren_i, id_flush_i, wb_valid_i, wb_rd_addr_i, wb_rd_wren_i,
        output stall_o, issue_o, pending_o, err_o
    );
endinterface

// File: rtl/raw_hazard_scoreboard.sv
// Per-register in-flight write counters; stalls ID on RAW hazards or counter saturation.
// Same-cycle writeback is treated as already visible, matching the negedge register file write.
module raw_hazard_scoreboard #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH  = 2
) (
    input logic                    clk_i,
    input logic                    rst_i,
    raw_hazard_scoreboard_if.slave sb
);
    localparam int unsigned NREG = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] cnt      [NREG];
    logic [CNT_WIDTH-1:0] cnt_next [NREG];
    logic [CNT_WIDTH-1:0] eff      [NREG];
    logic [NREG-1:0]      pending_next;
    logic                 ret;
    logic                 inc;
    logic                 haz1;
    logic                 haz2;
    logic                 sat;
    logic                 err_next;

    assign ret = sb.wb_valid_i & sb.wb_rd_wren_i & (sb.wb_rd_addr_i != '0);

    // Effective count as seen by ID; a zero-count retire is an error and must not wrap to nonzero.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            eff[r] = cnt[r];
            if (ret && sb.wb_rd_addr_i == ADDR_WIDTH'(r) && cnt[r] != '0)
                eff[r] = cnt[r] - CNT_ONE;
        end
    end

    always_comb begin
        haz1 = sb.id_rs1_used_i & (sb.id_rs1_addr_i != '0) & (eff[sb.id_rs1_addr_i] != '0);
        haz2 = sb.id_rs2_used_i & (sb.id_rs2_addr_i != '0) & (eff[sb.id_rs2_addr_i] != '0);
        sat  = sb.id_rd_wren_i  & (sb.id_rd_addr_i  != '0) & (eff[sb.id_rd_addr_i]  == CNT_MAX);
        sb.stall_o = sb.id_valid_i & ~sb.id_flush_i & (haz1 | haz2 | sat);
        sb.issue_o = sb.id_valid_i & ~sb.id_flush_i & ~sb.stall_o;
        inc        = sb.issue_o & sb.id_rd_wren_i & (sb.id_rd_addr_i != '0);
    end

    always_comb begin
        err_next     = sb.err_o;
        cnt_next[0]  = '0;
        pending_next = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            cnt_next[r] = cnt[r];
            if (inc && sb.id_rd_addr_i == ADDR_WIDTH'(r) &&
                !(ret && sb.wb_rd_addr_i == ADDR_WIDTH'(r))) begin
                cnt_next[r] = cnt[r] + CNT_ONE;
            end else if (ret && sb.wb_rd_addr_i == ADDR_WIDTH'(r) &&
                         !(inc && sb.id_rd_addr_i == ADDR_WIDTH'(r))) begin
                if (cnt[r] == '0)
                    err_next = 1'b1;
                else
                    cnt_next[r] = cnt[r] - CNT_ONE;
            end
            pending_next[r] = (cnt_next[r] != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt          <= '{default: '0};
            sb.pending_o <= '0;
            sb.err_o     <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            sb.pending_o <= pending_next;
            sb.err_o     <= err_next;
        end
    end
endmodule

// File: tb/tb_raw_hazard_scoreboard.sv
// Directed scenarios plus randomized traffic against a counting reference model.
module tb_raw_hazard_scoreboard;
    localparam int AW   = 5;
    localparam int NREG = 32;
    localparam int CMAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    int cnt_m [NREG];
    bit err_m;

    raw_hazard_scoreboard_if #(.ADDR_WIDTH(AW)) b ();

    raw_hazard_scoreboard #(.ADDR_WIDTH(AW), .CNT_WIDTH(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sb    (b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit w, input bit f);
        b.id_valid_i    = v;
        b.id_rs1_addr_i = AW'(rs1);
        b.id_rs1_used_i = u1;
        b.id_rs2_addr_i = AW'(rs2);
        b.id_rs2_used_i = u2;
        b.id_rd_addr_i  = AW'(rd);
        b.id_rd_wren_i  = w;
        b.id_flush_i    = f;
    endtask

    task automatic set_wb(input bit v, input int rd, input bit w);
        b.wb_valid_i   = v;
        b.wb_rd_addr_i = AW'(rd);
        b.wb_rd_wren_i = w;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0, 0);
    endtask

    // Reference: outstanding writes per register, with writeback visible in the same cycle.
    function automatic int eff_m(input int a, input bit ret, input int wa);
        int e;
        if (a == 0) return 0;
        e = cnt_m[a] - ((ret && wa == a) ? 1 : 0);
        return (e < 0) ? 0 : e;
    endfunction

    task automatic cycle();
        bit ret, h1, h2, sat, stall_e, issue_e, inc;
        int wa, rd, nv;
        logic [31:0] pend_e;
        @(negedge clk);
        wa  = int'(b.wb_rd_addr_i);
        rd  = int'(b.id_rd_addr_i);
        ret = b.wb_valid_i && b.wb_rd_wren_i && wa != 0;
        h1  = b.id_rs1_used_i && eff_m(int'(b.id_rs1_addr_i), ret, wa) != 0;
        h2  = b.id_rs2_used_i && eff_m(int'(b.id_rs2_addr_i), ret, wa) != 0;
        sat = b.id_rd_wren_i && rd != 0 && eff_m(rd, ret, wa) == CMAX;
        stall_e = b.id_valid_i && !b.id_flush_i && (h1 || h2 || sat);
        issue_e = b.id_valid_i && !b.id_flush_i && !stall_e;
        inc     = issue_e && b.id_rd_wren_i && rd != 0;
        pend_e  = '0;
        for (int r = 1; r < NREG; r++) pend_e[r] = (cnt_m[r] != 0);
        check("stall",   32'(b.stall_o), 32'(stall_e));
        check("issue",   32'(b.issue_o), 32'(issue_e));
        check("pending", b.pending_o,    pend_e);
        check("err",     32'(b.err_o),   32'(err_m));
        if (rst) begin
            for (int r = 0; r < NREG; r++) cnt_m[r] = 0;
            err_m = 0;
        end else begin
            if (inc) cnt_m[rd] = cnt_m[rd] + 1;
            if (ret) begin
                nv = cnt_m[wa] - 1;
                if (nv < 0) begin
                    nv    = 0;
                    err_m = 1;
                end
                cnt_m[wa] = nv;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) cnt_m[r] = 0;
        err_m = 0;
        idle();
        rst = 1;
        cycle(); cycle();
        rst = 0;
        cycle();

        // RAW: produce r5, consumer stalls two cycles, then issues on the retire cycle
        set_id(1, 0, 0, 0, 0, 5, 1, 0); cycle();
        set_id(1, 5, 1, 0, 0, 6, 0, 0); cycle(); cycle();
        set_wb(1, 5, 1); cycle();
        idle(); cycle();

        // x0: rd=0 never tracked; fill r1..r31, then sources of r0 never stall
        set_id(1, 0, 0, 0, 0, 0, 1, 0); cycle();
        for (int r = 1; r < NREG; r++) begin
            set_id(1, 0, 0, 0, 0, r, 1, 0); cycle();
        end
        set_id(1, 0, 1, 0, 1, 0, 0, 0); set_wb(1, 0, 1); cycle();
        idle();
        for (int r = 1; r < NREG; r++) begin
            set_wb(1, r, 1); cycle();
        end
        idle(); cycle();

        // WAW saturation on r7, fourth issue released by same-cycle retire
        for (int i = 0; i < 3; i++) begin
            set_id(1, 0, 0, 0, 0, 7, 1, 0); cycle();
        end
        cycle();
        set_wb(1, 7, 1); cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            set_wb(1, 7, 1); cycle();
        end
        idle(); cycle();

        // Simultaneous inc/dec on r9, then a flushed consumer
        set_id(1, 0, 0, 0, 0, 9, 1, 0); cycle();
        set_id(1, 0, 0, 0, 0, 9, 1, 0); set_wb(1, 9, 1); cycle();
        idle(); set_id(1, 9, 1, 0, 0, 3, 1, 1); cycle();
        idle(); set_wb(1, 9, 1); cycle();
        idle(); cycle();

        // Reset mid-traffic with cnt[5]=2
        set_id(1, 0, 0, 0, 0, 5, 1, 0); cycle(); cycle();
        set_id(1, 5, 1, 0, 0, 5, 1, 0); rst = 1; cycle(); cycle();
        rst = 0; cycle(); cycle();
        idle(); cycle();

        // Spurious retire sets a sticky error
        set_wb(1, 4, 1); cycle();
        idle();
        for (int i = 0; i < 12; i++) cycle();
        rst = 1; cycle();
        rst = 0; cycle();

        // Randomized traffic over a small register window to create frequent hazards
        for (int i = 0; i < 1500; i++) begin
            int rmax, wr;
            rmax = ($urandom_range(0, 9) == 0) ? NREG - 1 : 7;
            set_id($urandom_range(0, 3) != 0,
                   $urandom_range(0, rmax), $urandom_range(0, 1),
                   $urandom_range(0, rmax), $urandom_range(0, 1),
                   $urandom_range(0, rmax), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 15) == 0);
            set_wb(0, 0, 0);
            if ($urandom_range(0, 1) == 1) begin
                wr = $urandom_range(1, NREG - 1);
                for (int k = 0; k < 8 && cnt_m[wr] == 0; k++) wr = $urandom_range(0, 7);
                if (cnt_m[wr] != 0 || wr == 0 || $urandom_range(0, 40) == 0)
                    set_wb(1, wr, $urandom_range(0, 7) != 0);
            end
            rst = ($urandom_range(0, 120) == 0);
            cycle();
        end
        rst = 0;
        idle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
